// File: rtl/conv_encoder.sv
// ---------------------------------------------------------------------------
// conv_encoder
// Rate-1/2 feedforward convolutional encoder. One information bit in per
// handshake, one coded pair {G0 parity, G1 parity} out per bit.
//
// Build option: TAIL_FLUSH_EN
//   defined   - each frame is closed with K-1 zero-input tail pairs so the
//               trellis ends in state 0.
//   undefined - no tail pairs; the in_last pair carries out_last and the
//               shift register is cleared on that edge (truncated frame).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame open, shift register is all zero
// DATA  | frame open, information bits being encoded
// TAIL  | flushing K-1 zero bits, input side held off (TAIL_FLUSH_EN only)
// ---------------------------------------------------------------------------
module conv_encoder #(
   parameter int             K  = 3,
   parameter logic [K-1:0]   G0 = 3'b111,
   parameter logic [K-1:0]   G1 = 3'b101
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_bit,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [1:0] out_pair,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } state_e;

   state_e       state_q;
   logic [K-2:0] s_q;
   logic [1:0]   out_pair_q;
   logic         out_valid_q;
   logic         out_last_q;

`ifdef TAIL_FLUSH_EN
   localparam int CW = $clog2(K) + 1;
   logic [CW-1:0] cnt_q;
`endif

   logic         load_ok;
   logic         accept;
   logic         u;
   logic [K-1:0] w;
   logic [1:0]   pair_d;
   logic [K-2:0] s_d;

   // A new pair may be loaded whenever the output register is empty or draining.
   assign load_ok  = !out_valid_q || out_ready;
   assign in_ready = (state_q != TAIL) && load_ok;
   assign accept   = in_valid && in_ready;

   // Encoder window: current input on top, oldest past bit at bit 0.
   always_comb begin
      u      = (state_q == TAIL) ? 1'b0 : in_bit;
      w      = {u, s_q};
      pair_d = {^(w & G0), ^(w & G1)};
      s_d    = w[K-1:1];
   end

   // Frame sequencing, shift register and registered output pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         s_q         <= '0;
         out_pair_q  <= 2'b00;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
`ifdef TAIL_FLUSH_EN
         cnt_q       <= '0;
`endif
      end else begin
`ifdef TAIL_FLUSH_EN
         if (state_q == TAIL) begin
            if (load_ok) begin
               out_pair_q  <= pair_d;
               out_valid_q <= 1'b1;
               out_last_q  <= (cnt_q == CW'(1));
               s_q         <= s_d;
               cnt_q       <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= IDLE;
               end
            end
         end else if (accept) begin
            out_pair_q  <= pair_d;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            s_q         <= s_d;
            if (in_last) begin
               state_q <= TAIL;
               cnt_q   <= CW'(K - 1);
            end else begin
               state_q <= DATA;
            end
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
`else
         if (accept) begin
            out_pair_q  <= pair_d;
            out_valid_q <= 1'b1;
            out_last_q  <= in_last;
            if (in_last) begin
               // Truncated frame: restart the trellis from state 0.
               s_q     <= '0;
               state_q <= IDLE;
            end else begin
               s_q     <= s_d;
               state_q <= DATA;
            end
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
`endif
      end
   end

   assign out_pair  = out_pair_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_conv_encoder.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder
// Reference model: each coded pair is the GF(2) convolution of the frame's bit
// history with the generator taps; tail pairs come from appending K-1 zeros.
// ---------------------------------------------------------------------------
module tb_conv_encoder;

   localparam int         K  = 3;
   localparam logic [2:0] G0 = 3'b111;
   localparam logic [2:0] G1 = 3'b101;
`ifdef TAIL_FLUSH_EN
   localparam bit TAIL_ON = 1'b1;
`else
   localparam bit TAIL_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_bit = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [1:0] out_pair;
   logic       out_valid;
   logic       out_last;
   logic       out_ready = 1'b0;
   logic       busy;

   conv_encoder #(.K(K), .G0(G0), .G1(G1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_pair  (out_pair),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [2:0] exp_q[$];   // {last, pair} expected in order
   logic [2:0] got_q[$];   // every pair handed downstream
   int         hist[$];    // bits of the current frame (model)

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Pair for the newest bit of hist: XOR of taps over the last K bits.
   function automatic logic [1:0] model_pair();
      logic p1, p0;
      int   idx, x;
      p1 = 1'b0;
      p0 = 1'b0;
      for (int j = 0; j < K; j++) begin
         idx = hist.size() - 1 - j;
         x   = (idx >= 0) ? hist[idx] : 0;
         if (x != 0) begin
            p1 = p1 ^ G0[K-1-j];
            p0 = p0 ^ G1[K-1-j];
         end
      end
      return {p1, p0};
   endfunction

   task automatic model_accept(input bit b, input bit last);
      logic [1:0] p;
      hist.push_back(int'(b));
      p = model_pair();
      if (TAIL_ON) begin
         exp_q.push_back({1'b0, p});
         if (last) begin
            for (int t = 1; t < K; t++) begin
               hist.push_back(0);
               p = model_pair();
               exp_q.push_back({(t == K - 1), p});
            end
         end
      end else begin
         exp_q.push_back({last, p});
      end
      if (last) hist.delete();
   endtask

   // Compare process: samples well after the negedge, inputs settled.
   bit         have_prev = 1'b0;
   bit         prev_stall = 1'b0;
   logic [2:0] prev_out = 3'b000;
   initial begin
      logic [2:0] e;
      forever begin
         @(negedge clk);
         #3;
         if (!rst_n) begin
            have_prev  = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (have_prev && prev_stall) begin
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_hold", 32'({out_last, out_pair}), 32'(prev_out));
            end
            if (out_valid) check("busy_with_valid", 32'(busy), 32'd1);
            if (out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
               got_q.push_back({out_last, out_pair});
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pair: got %0h expected none", {out_last, out_pair});
               end else begin
                  e = exp_q.pop_front();
                  check("pair", 32'(out_pair), 32'(e[1:0]));
                  check("last", 32'(out_last), 32'(e[2]));
               end
            end
            have_prev  = 1'b1;
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_last, out_pair};
         end
      end
   end

   // Present a bit until accepted; returns at posedge+1 with in_valid dropped.
   task automatic send_bit(input bit b, input bit last, input int pct);
      bit acc;
      acc = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         #1;
         out_ready = ($urandom_range(99) < pct);
         in_valid  = 1'b1;
         in_bit    = b;
         in_last   = last;
         #3;
         if (in_ready) begin
            model_accept(b, last);
            acc = 1'b1;
            break;
         end
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept expected accept");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle_cycle(input int pct);
      @(negedge clk);
      #1;
      out_ready = ($urandom_range(99) < pct);
      in_valid  = 1'b0;
   endtask

   task automatic drain(input int pct);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 500; c++) begin
         idle_cycle(pct);
         #3;
         if (exp_q.size() == 0 && !out_valid) begin
            done = 1'b1;
            break;
         end
      end
      check("drain_done", 32'(done), 32'd1);
      check("busy_after_frame", 32'(busy), 32'd0);
   endtask

   task automatic check_seq(input string name, input logic [2:0] e[$]);
      check({name, "_len"}, 32'(got_q.size()), 32'(e.size()));
      for (int i = 0; i < e.size() && i < got_q.size(); i++)
         check(name, 32'(got_q[i]), 32'(e[i]));
   endtask

   initial begin
      logic [2:0] e[$];
      int len, pct;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_pair", 32'(out_pair), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      rst_n = 1'b1;
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);

      // Frame 1,0,1,1
      got_q.delete();
      send_bit(1'b1, 1'b0, 100);
      send_bit(1'b0, 1'b0, 100);
      send_bit(1'b1, 1'b0, 100);
      send_bit(1'b1, 1'b1, 100);
      drain(100);
      if (TAIL_ON) e = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
      else         e = '{3'b011, 3'b010, 3'b000, 3'b101};
      check_seq("frame_1011", e);

      // Single-bit frame, and in_ready during the tail
      got_q.delete();
      send_bit(1'b1, 1'b1, 100);
      for (int i = 0; i < 3; i++) begin
         idle_cycle(100);
         #3;
         check("single_in_ready", 32'(in_ready), (TAIL_ON && i < 2) ? 32'd0 : 32'd1);
      end
      drain(100);
      if (TAIL_ON) e = '{3'b011, 3'b010, 3'b111};
      else         e = '{3'b111};
      check_seq("single_bit", e);

      // Backpressure mid-frame: 1,1,<stall x3>,0,1(last)
      got_q.delete();
      send_bit(1'b1, 1'b0, 100);
      send_bit(1'b1, 1'b0, 100);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         out_ready = 1'b0;
         in_valid  = 1'b1;
         in_bit    = 1'b0;
         in_last   = 1'b0;
         #3;
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_valid", 32'(out_valid), 32'd1);
      end
      send_bit(1'b0, 1'b0, 100);
      send_bit(1'b1, 1'b1, 100);
      drain(100);
      if (TAIL_ON) e = '{3'b011, 3'b001, 3'b001, 3'b000, 3'b010, 3'b111};
      else         e = '{3'b011, 3'b001, 3'b001, 3'b100};
      check_seq("backpressure", e);

      // Reset mid-frame with a pair pending
      send_bit(1'b1, 1'b0, 100);
      send_bit(1'b0, 1'b0, 100);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_pair", 32'(out_pair), 32'd0);
      check("midrst_last", 32'(out_last), 32'd0);
      exp_q.delete();
      hist.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #3;
      check("postrst_busy", 32'(busy), 32'd0);
      check("postrst_in_ready", 32'(in_ready), 32'd1);
      got_q.delete();
      send_bit(1'b1, 1'b0, 100);
      send_bit(1'b1, 1'b1, 100);
      drain(100);
      if (TAIL_ON) e = '{3'b011, 3'b001, 3'b001, 3'b111};
      else         e = '{3'b011, 3'b101};
      check_seq("after_reset", e);

      // Random frames, random downstream readiness
      for (int f = 0; f < 30; f++) begin
         len = $urandom_range(64, 1);
         pct = $urandom_range(100, 30);
         for (int i = 0; i < len; i++)
            send_bit(1'($urandom_range(1)), (i == len - 1), pct);
         drain(pct);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/2 feedforward convolutional encoder; the transmit-side counterpart of the Viterbi decoder's branch metric units.
- Consumes one information bit per handshake and produces one coded pair per bit.
- Pair bit order matches the decoder's received-pair input: bit 1 from G0, bit 0 from G1.
- Terminates each frame in state 0, where decoder traceback starts.

Parameters:
K, 3, constraint length (>=2); the shift register holds K-1 past bits
G0, 3'b111, generator polynomial for out_pair[1]; bit K-1 taps the current input, bit 0 the oldest bit
G1, 3'b101, generator polynomial for out_pair[0]; same tap order as G0

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-low
in_bit  input  1  information bit
in_valid  input  1  in_bit/in_last valid
in_last  input  1  marks the final information bit of a frame
in_ready  output  1  encoder can accept a bit this cycle
out_pair  output  2  coded pair {G0 parity, G1 parity}
out_valid  output  1  out_pair valid
out_last  output  1  marks the final pair of a frame
out_ready  input  1  downstream accepts out_pair
busy  output  1  frame in progress or output pending

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, out_pair=2'b00, out_last=0.
  - Shift register s[K-2:0]=0, FSM=IDLE, tail counter=0.
  - in_ready=1 and busy=0 once reset is released.
- Window and outputs:
  - w[K-1:0] = {u, s[K-2:0]}, where u = in_bit in IDLE/DATA and u = 0 in TAIL.
  - out_pair[1] = ^(w & G0); out_pair[0] = ^(w & G1).
  - Next s = w[K-1:1].
- Handshakes:
  - in_ready = (FSM != TAIL) && (!out_valid || out_ready). Purely combinational, no dependence on in_valid.
  - An input is accepted when in_valid && in_ready.
  - On the accepting edge: out_pair/out_last are registered, s updates, and out_valid is set.
  - Latency: one cycle from acceptance to out_valid.
  - out_pair/out_last stay stable while out_valid && !out_ready.
  - out_valid clears when out_ready is high and no new pair is loaded.
  - Throughput: one pair per cycle while out_ready is held high.
- FSM:
  - IDLE: s==0, no frame. Accepted bit without in_last -> DATA. Accepted bit with in_last -> TAIL (single-bit frame).
  - DATA: accepted bit with in_last -> TAIL with tail counter = K-1; otherwise stay in DATA.
  - TAIL: each cycle with (!out_valid || out_ready), encode u=0, load the pair, and decrement the counter.
  - TAIL: out_last=1 on the pair that brings the counter to 0; then -> IDLE, with s==0 guaranteed.
- busy = (FSM != IDLE) || out_valid.
- Boundaries:
  - in_valid while in_ready=0 (output stalled, or in TAIL): ignored, no state change. The source must hold its data.
  - in_last with no preceding bits is legal and yields 1+(K-1) pairs.
  - Back-to-back frames: the first bit of the next frame is accepted the cycle after the last tail pair loads, provided out_ready is high.
- Reset mid-frame: the partial frame and any pending pair are discarded, and all outputs return to reset values asynchronously.

Optional Feature:
TAIL_FLUSH_EN
- Defined: zero-tail termination as described above; K-1 tail pairs per frame.
- Undefined: no TAIL state and no tail pairs.
  - out_last is set on the pair of the in_last bit itself.
  - On that edge s is cleared to 0 and the FSM -> IDLE (truncated frame; the next frame starts from state 0).
  - in_ready never deasserts for termination.

Test Plan:
- TAIL_FLUSH_EN, K=3, G=7/5, out_ready=1: bits 1,0,1,1 (in_last on the 4th) -> pairs 11,10,00,01,01,11; out_last only on the 6th; busy drops after it.
- Same stimulus without TAIL_FLUSH_EN -> pairs 11,10,00,01; out_last on the 4th; next frame bit 1 -> 11 (state cleared).
- Backpressure: out_ready=0 for 3 cycles mid-frame -> in_ready=0, out_pair held constant; on release the sequence continues unchanged with no lost or duplicated pair.
- Single-bit frame: in_bit=1 with in_last in IDLE -> 11,10,11; in_ready low during the 2 tail cycles.
- Reset: assert rst_n=0 after the 2nd bit with out_valid=1 -> out_valid/out_pair/out_last go to 0 immediately; the new frame 1,1(last) -> 11,01,01,11.
- Random frames of lengths 1–64 with random out_ready, checked against a reference model; additionally confirm state==0 at each frame end.
